// File: rtl/pipe_collect_pkg.sv
// Shared constants for the upstream result pipeline and its collector FIFO.
package pipe_collect_pkg;

  localparam int unsigned PIPE_N     = 10;
  localparam int unsigned PIPE_LAT   = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is deliberately left unreset.
module sync_fifo
  import pipe_collect_pkg::*;
#(
  parameter int unsigned N     = PIPE_N,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [N-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [N-1:0]           rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_wr, do_rd;

  assign full_o    = (level_q == DEPTH_L);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pipe_collect.sv
// Tracks issued operands through the upstream pipeline latency and collects
// the matching results into a FIFO, counting any that arrive while it is full.
module pipe_collect
  import pipe_collect_pkg::*;
#(
  parameter int unsigned N     = PIPE_N,
  parameter int unsigned LAT   = PIPE_LAT,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N-1:0]           F,
  output logic [N-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  logic [LAT-1:0]        tag_q, tag_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  push, drop;
  logic                  fifo_full, fifo_empty;

  assign push      = tag_q[LAT-1];
  assign out_valid = !fifo_empty;
  // Full implies non-empty, so a ready consumer always frees the slot this push needs.
  assign drop      = push && fifo_full && !out_ready;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    tag_d      = '0;
    tag_d[0]   = in_valid;
    for (int unsigned i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_data_i (F),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

endmodule

// File: doc/pipe_collect.md
PIPE_COLLECT -- requirements
Module: pipe_collect

Interface
REQ-001 Parameter N, default 10: data width of the pipelined result F.
REQ-002 Parameter LAT, default 3: upstream pipeline latency in clock edges, from operand capture to F being sampleable.
REQ-003 Parameter DEPTH, default 4: result FIFO depth, a power of two, minimum 2.
REQ-004 clk  in  1: single rising-edge clock, shared with the upstream pipeline.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 in_valid  in  1: high in the cycle operands A/B/C/D are presented to the upstream pipeline.
REQ-007 F  in  N: result bus from the upstream pipeline.
REQ-008 out_data  out  N: FIFO head result.
REQ-009 out_valid  out  1: FIFO non-empty.
REQ-010 out_ready  in  1: consumer accepts the head when out_valid is also high.
REQ-011 level  out  clog2(DEPTH)+1: current FIFO occupancy.
REQ-012 overflow  out  1: sticky flag, set when a result is dropped.
REQ-013 drop_cnt  out  8: count of dropped results, saturating at 255.

Function
REQ-014 A tag shift register of LAT bits shall track in_valid: tag[0] takes in_valid at each posedge, and tag[i] takes tag[i-1].
REQ-015 Push condition: tag[LAT-1] = 1 at a posedge. F is then written to the FIFO tail at that edge, so in_valid sampled at edge k is captured at edge k+LAT.
REQ-016 F shall be sampled only at posedge. Upstream propagation delays are below one clock period.
REQ-017 Pop condition: out_valid && out_ready at a posedge. The head pointer then advances.
REQ-018 out_data shall equal the oldest unpopped entry. Results leave in strict issue order.
REQ-019 out_data is don't-care while out_valid = 0. The bench shall not check it.
REQ-020 Push when full without a simultaneous pop: F is discarded, the FIFO is unchanged, overflow is set to 1, and drop_cnt increments.
REQ-021 Push when full with a simultaneous pop: both occur, nothing is dropped, and level stays at DEPTH.
REQ-022 Push when empty with a simultaneous pop: no pop occurs, because out_valid = 0; the push completes.
REQ-023 Push and pop together when neither full nor empty: level is unchanged.
REQ-024 Read and write pointers shall wrap modulo DEPTH.
REQ-025 level shall be maintained exactly within 0..DEPTH.
REQ-026 out_valid = (level != 0).
REQ-027 overflow shall clear only on reset.
REQ-028 drop_cnt shall hold at 255 once it reaches 255.
REQ-029 No arithmetic shall be applied to F. The modulo-2^N value is stored as received.

Reset
REQ-030 While rst_n = 0, all of the following shall be forced immediately, independent of clk: tag = 0, pointers = 0, level = 0, out_valid = 0, overflow = 0, drop_cnt = 0.
REQ-031 FIFO storage shall not be reset. out_data is therefore undefined until the first push.
REQ-032 A reset asserted mid-operation discards all in-flight tags and stored results.
REQ-033 After rst_n deasserts, the first push is possible no earlier than LAT edges after the first sampled in_valid.

Structure
REQ-034 A shared package shall hold PIPE_N (10), PIPE_LAT (3), FIFO_DEPTH (4) and the drop-counter width (8). The upstream pipeline and this block share them.
REQ-035 The FIFO shall be the single sub-module, sync_fifo: write/read enables, full/empty flags, level, with parameters N and DEPTH.
REQ-036 The tag shift register and drop logic shall reside in pipe_collect.

Verification
REQ-037 Single issue: the upstream pipeline is instantiated, A=5, B=3, C=10, D=2 with in_valid for 1 cycle, out_ready=1. Required: out_valid rises after edge k+3, out_data=18, and is popped next edge.
REQ-038 Wrap: A=1000, B=100, C=0, D=0. Required: out_data=76 (1100 mod 1024).
REQ-039 Back-to-back burst: in_valid for 4 cycles with F results 10, 20, 30, 40, out_ready=0. Required: level reaches 4 and overflow=0. Then out_ready=1 yields 10, 20, 30, 40 in order.
REQ-040 Overflow: out_ready=0 and 6 consecutive issues. Required: level=4, overflow=1, drop_cnt=2, and only the first 4 results are retained.
REQ-041 Full with simultaneous push and pop: FIFO full, out_ready=1, and one more push arrives. Required: no drop, level stays 4, overflow stays 0.
REQ-042 Reset mid-operation: rst_n pulled low between clock edges with 2 entries stored and 2 tags in flight. Required: out_valid=0 and level=0 immediately, and no push occurs after release.
